// File: rtl/pcie_lane_scheduler_if.sv
// Requester-side handshakes and serializer-side outputs of the lane scheduler.
interface pcie_lane_scheduler_if;
   logic       valid0;
   logic [7:0] data0;
   logic       ready0;
   logic       valid1;
   logic [7:0] data1;
   logic       ready1;
   logic [7:0] data_out;
   logic       k_out;
   logic       load;
   logic       valid_out;
   logic       link_up;

   modport master (
      output valid0, data0, valid1, data1,
      input  ready0, ready1, data_out, k_out, load, valid_out, link_up
   );

   modport slave (
      input  valid0, data0, valid1, data1,
      output ready0, ready1, data_out, k_out, load, valid_out, link_up
   );
endinterface

// File: rtl/pcie_lane_scheduler.sv
// Shares one 8-bit serializer lane between two requesters: COM training, then
// round-robin bounded bursts separated by a COM slot, one symbol per 8 cycles.
module pcie_lane_scheduler #(
   parameter int unsigned TRAIN_SYMS = 4,
   parameter int unsigned MAX_BURST  = 4,
   parameter logic [7:0]  COM_SYM    = 8'hBC
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   pcie_lane_scheduler_if.slave  lane
);

   localparam int unsigned CNT_W   = 3;
   localparam int unsigned TRAIN_W = $clog2(TRAIN_SYMS) + 1;
   localparam int unsigned BURST_W = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {
      ST_TRAIN = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [TRAIN_W-1:0]   train_cnt_q, train_cnt_d;
   logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic                 owner_q, owner_d;
   logic                 last_owner_q, last_owner_d;
   logic [7:0]           data_out_q, data_out_d;
   logic                 k_out_q, k_out_d;
   logic                 load_q;
   logic                 valid_out_q;
   logic                 link_up_q, link_up_d;
   logic                 ready0_c, ready1_c;

   logic slot_c;
   logic any_valid_c;
   logic grant_c;
   logic owner_valid_c;
   logic burst_more_c;
   logic train_last_c;

   assign slot_c        = (cnt_q == CNT_W'(7));
   assign any_valid_c   = lane.valid0 | lane.valid1;
   // Tie goes to whoever did not own the previous burst.
   assign grant_c       = (lane.valid0 & lane.valid1) ? ~last_owner_q : lane.valid1;
   assign owner_valid_c = owner_q ? lane.valid1 : lane.valid0;
   assign burst_more_c  = owner_valid_c && (burst_cnt_q < BURST_W'(MAX_BURST));
   assign train_last_c  = (train_cnt_q == TRAIN_W'(TRAIN_SYMS - 1));

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_TRAIN;
      end else begin
         state_q <= state_d;
      end
   end

   // Slot counter, datapath and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= '0;
         train_cnt_q  <= '0;
         burst_cnt_q  <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         data_out_q   <= 8'h00;
         k_out_q      <= 1'b0;
         load_q       <= 1'b0;
         valid_out_q  <= 1'b0;
         link_up_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_q + CNT_W'(1);
         train_cnt_q  <= train_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         data_out_q   <= data_out_d;
         k_out_q      <= k_out_d;
         load_q       <= slot_c;
         valid_out_q  <= valid_out_q | slot_c;
         link_up_q    <= link_up_d;
      end
   end

   // Next-state logic, evaluated only at the slot decision cycle
   always_comb begin
      state_d = state_q;
      if (slot_c) begin
         case (state_q)
            ST_TRAIN: if (train_last_c)  state_d = ST_IDLE;
            ST_IDLE:  if (any_valid_c)   state_d = ST_BURST;
            ST_BURST: if (!burst_more_c) state_d = ST_IDLE;
            default:                     state_d = ST_TRAIN;
         endcase
      end
   end

   // Slot contents, take strobes and bookkeeping
   always_comb begin
      train_cnt_d  = train_cnt_q;
      burst_cnt_d  = burst_cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      data_out_d   = data_out_q;
      k_out_d      = k_out_q;
      link_up_d    = link_up_q;
      ready0_c     = 1'b0;
      ready1_c     = 1'b0;
      if (slot_c) begin
         case (state_q)
            ST_TRAIN: begin
               data_out_d = COM_SYM;
               k_out_d    = 1'b1;
               if (train_last_c) begin
                  link_up_d = 1'b1;
               end else begin
                  train_cnt_d = train_cnt_q + TRAIN_W'(1);
               end
            end
            ST_IDLE: begin
               if (any_valid_c) begin
                  owner_d     = grant_c;
                  burst_cnt_d = BURST_W'(1);
                  data_out_d  = grant_c ? lane.data1 : lane.data0;
                  k_out_d     = 1'b0;
                  ready0_c    = ~grant_c;
                  ready1_c    = grant_c;
               end else begin
                  data_out_d = COM_SYM;
                  k_out_d    = 1'b1;
               end
            end
            ST_BURST: begin
               if (burst_more_c) begin
                  burst_cnt_d = burst_cnt_q + BURST_W'(1);
                  data_out_d  = owner_q ? lane.data1 : lane.data0;
                  k_out_d     = 1'b0;
                  ready0_c    = ~owner_q;
                  ready1_c    = owner_q;
               end else begin
                  // Separator slot closes the burst.
                  data_out_d   = COM_SYM;
                  k_out_d      = 1'b1;
                  last_owner_d = owner_q;
               end
            end
            default: begin
               data_out_d = COM_SYM;
               k_out_d    = 1'b1;
            end
         endcase
      end
   end

   assign lane.ready0    = ready0_c;
   assign lane.ready1    = ready1_c;
   assign lane.data_out  = data_out_q;
   assign lane.k_out     = k_out_q;
   assign lane.load      = load_q;
   assign lane.valid_out = valid_out_q;
   assign lane.link_up   = link_up_q;

endmodule

// File: doc/pcie_lane_scheduler.md
Name: pcie_lane_scheduler

Overview:
Sequences and shares the single 8-bit parallel-to-serial lane between two byte-stream requesters. After reset it runs a link-training phase of COM symbols (0xBC, K28.5), then arbitrates the lane round-robin in bounded bursts. It inserts one COM separator slot between bursts and on idle. It sits between the requesters and the serializer. Once per 8-cycle byte slot it presents DATA_OUT/K_OUT with a LOAD strobe.

Parameters:
TRAIN_SYMS, 4, number of COM slots sent after reset before link is up (≥1)
MAX_BURST, 4, maximum data bytes granted to one requester per burst (≥1)
COM_SYM, 8'hBC, control symbol used for training, separator and idle

Ports:
CLK  input  1  lane clock (one serial bit per cycle)
RESET  input  1  asynchronous, active-low reset
VALID0  input  1  requester 0 has a byte on DATA0
DATA0  input  8  requester 0 byte; held stable while VALID0 high
READY0  output  1  byte on DATA0 taken at this rising edge (transfer = VALID0 & READY0)
VALID1  input  1  requester 1 byte valid
DATA1  input  8  requester 1 byte
READY1  output  1  requester 1 take strobe
DATA_OUT  output  8  byte to serializer
K_OUT  output  1  1 = DATA_OUT is a control symbol
LOAD  output  1  one-cycle strobe: serializer latches DATA_OUT/K_OUT
VALID_OUT  output  1  lane carrying symbols (high from first LOAD onward)
LINK_UP  output  1  training complete

Behaviour:
- Reset (RESET=0, async): slot counter cnt=0; state=TRAIN; train_cnt=0; burst_cnt=0; last_owner=1 (requester 0 wins the first tie); DATA_OUT=0x00; K_OUT=0; LOAD=0; VALID_OUT=0; LINK_UP=0; READY0/1=0.
- Slot timing: 3-bit cnt increments every cycle and wraps 7→0. Slot decision is made in the cycle with cnt==7. At that rising edge DATA_OUT/K_OUT are registered. LOAD is high for exactly the following cycle (cnt==0). The first LOAD is at the 8th rising edge after reset release, so LOAD has a period of 8 cycles.
- READYn is combinational. It is high only during cnt==7, and only when requester n's byte is selected. No other cycle asserts READY. VALIDn is sampled only at cnt==7 and may change freely otherwise.
- TRAIN: each slot sends COM_SYM with K=1. When train_cnt reaches TRAIN_SYMS-1, the next state is IDLE. LINK_UP rises with the last training LOAD. VALIDn is ignored during TRAIN.
- IDLE, at a slot:
  - If any VALID is high, grant one requester. If both are high, grant the one ≠ last_owner. Send its byte with K=0, pulse READY, set burst_cnt=1 and owner, and enter BURST.
  - If neither VALID is high, send COM_SYM with K=1.
- BURST, at a slot:
  - If VALID_owner=1 and burst_cnt<MAX_BURST: send the owner byte with K=0, pulse READY_owner, and increment burst_cnt.
  - Otherwise: send one COM_SYM with K=1 as separator, set last_owner=owner, and return to IDLE.
  - The non-owner is never granted inside a burst.
- Gap rule: at least one COM slot separates any two bursts, including back-to-back bursts from the same requester.
- MAX_BURST=1: every data byte is followed by a COM slot.
- VALID_OUT is set at the first LOAD and stays high until reset. LINK_UP stays high until reset.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - An in-progress burst is abandoned; no READY is issued.
  - Training restarts.
- Width: burst_cnt and train_cnt are wide enough for their parameter (clog2+1).

Test Plan:
1. Training: release RESET at cycle 3 with both VALIDs=1. Required: LOAD pulses every 8 cycles; the first 4 LOADs carry 0xBC with K=1; READY0/1 stay 0 throughout; LINK_UP rises with the 4th LOAD.
2. Single requester: VALID0=1 with bytes 0x25, 0xF9, 0x4F, then VALID0=0. Required: LOAD sequence 0x25, 0xF9, 0x4F (K=0), then 0xBC (K=1); one READY0 pulse per byte, each at cnt==7.
3. Contention: both VALIDs held high, DATA0=0xA6, DATA1=0x39, MAX_BURST=4. Required: 4×0xA6, BC, 4×0x39, BC, 4×0xA6, and so on; requester 0 goes first.
4. Burst cut: VALID1 alone held high, MAX_BURST=2. Required: 0x39, 0x39, BC, 0x39, 0x39, BC; READY1 never asserted in the separator slot.
5. VALID drop: VALID0 deasserted after 1 byte while VALID1=1. Required: one 0xA6, then BC, then requester 1 granted in the next slot.
6. Reset mid-burst: assert RESET during the 2nd byte of a burst. Required: outputs immediately at reset values; after release, TRAIN_SYMS COMs are sent before any data, and the first data slot is granted to requester 0.
